ram_sp_param: RTL and testbench

- Parametrised single-port synchronous RAM that replaces the fixed 128x16 program/data store.
- Adds configurable width and depth, per-lane write masking, and a selectable read-during-write result.
- Adds a req/ready handshake and a hardware clear sequencer that fills the array after reset, so the core never fetches uninitialised words.
- Sits between the processor core and its memory wrapper.

---
 rtl/ram_sp_param.sv | 91 +++++++++
 tb/tb_ram_sp_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with per-lane write mask, selectable
// read-during-write result and a post-reset clear sweep that fills the array.
module ram_sp_param #(
  parameter int                 DATA_W         = 16,
  parameter int                 ADDR_W         = 7,
  parameter int                 LANE_W         = 8,
  parameter int                 RDW_MODE       = 1,
  parameter int                 CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL       = '0,
  localparam int                NL             = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic [NL-1:0]     wmask,
  output logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              init_busy
);

  // Handshake: an access is taken on a rising edge where req && ready. ready is
  // low for the whole clear sweep, and req seen while ready is low is dropped.

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
  localparam logic [ADDR_W-1:0] PTR_LAST  = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;

  assign accept  = req && ready;
  assign rd_word = mem[addr];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NL; i++) begin
      if (wmask[i]) merged[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
    end
  end

  // Array has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == ST_INIT)    mem[ptr]  <= INIT_VAL;
      else if (accept && wr)   mem[addr] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RST_STATE;
      ptr        <= '0;
      ready      <= 1'b0;
      init_busy  <= (CLEAR_ON_RESET != 0);
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          ptr <= ptr + PTR_ONE;
          if (ptr == PTR_LAST) begin
            state     <= ST_IDLE;
            ready     <= 1'b1;
            init_busy <= 1'b0;
          end
        end
        ST_IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            dout       <= (wr && (RDW_MODE != 0)) ? merged : rd_word;
            dout_valid <= !wr;
          end
        end
        default: state <= RST_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: two 128x16 instances (write-first and
// read-first) sharing stimulus, plus a 16x32 instance without the clear sweep.
module tb_ram_sp_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req, wr;
  logic [6:0]  addr;
  logic [15:0] din;
  logic [1:0]  wmask;
  logic        ready_a, valid_a, busy_a, ready_b, valid_b, busy_b;
  logic [15:0] dout_a, dout_b;

  logic        c_req, c_wr;
  logic [3:0]  c_addr;
  logic [31:0] c_din;
  logic [3:0]  c_wmask;
  logic        c_ready, c_valid, c_busy;
  logic [31:0] c_dout;

  ram_sp_param #(.RDW_MODE(1)) dut_a (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .din(din),
    .wmask(wmask), .ready(ready_a), .dout(dout_a), .dout_valid(valid_a),
    .init_busy(busy_a));

  ram_sp_param #(.RDW_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .din(din),
    .wmask(wmask), .ready(ready_b), .dout(dout_b), .dout_valid(valid_b),
    .init_busy(busy_b));

  ram_sp_param #(.DATA_W(32), .ADDR_W(4), .LANE_W(8), .RDW_MODE(1),
                 .CLEAR_ON_RESET(0), .INIT_VAL(32'h0)) dut_c (
    .clk(clk), .reset(reset), .req(c_req), .wr(c_wr), .addr(c_addr), .din(c_din),
    .wmask(c_wmask), .ready(c_ready), .dout(c_dout), .dout_valid(c_valid),
    .init_busy(c_busy));

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [6:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    req = r; wr = w; addr = a; din = d; wmask = m;
  endtask

  // Counts edges from reset release until ready rises, checking busy meanwhile.
  task automatic count_sweep(input string name, input int start);
    int cnt;
    int busy_bad;
    cnt = start;
    busy_bad = 0;
    while (!ready_a && cnt < 400) begin
      if (!busy_a || !busy_b || ready_b) busy_bad++;
      tick();
      cnt++;
    end
    chk({name, "_len"}, cnt, 128);
    chk({name, "_busy_during"}, busy_bad, 0);
    chk({name, "_busy_after"}, {busy_a, busy_b, ready_b}, 3'b001);
  endtask

  typedef struct {
    logic        req;
    logic        wr;
    logic [6:0]  addr;
    logic [15:0] din;
    logic [1:0]  wmask;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_v;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 7'h01, 16'h0019, 2'b11, 16'h0019, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 7'h01, 16'h0000, 2'b00, 16'h0019, 16'h0019, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 7'h02, 16'h0010, 2'b11, 16'h0010, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 7'h01, 16'h0000, 2'b00, 16'h0019, 16'h0019, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 7'h02, 16'h0000, 2'b00, 16'h0010, 16'h0010, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 7'h03, 16'hA5A5, 2'b11, 16'hA5A5, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 7'h03, 16'h1234, 2'b01, 16'hA534, 16'hA5A5, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 7'h03, 16'h0000, 2'b00, 16'hA534, 16'hA534, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 7'h03, 16'hA5A5, 2'b11, 16'hA5A5, 16'hA534, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 7'h03, 16'h1234, 2'b00, 16'hA5A5, 16'hA5A5, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 7'h03, 16'h0000, 2'b00, 16'hA5A5, 16'hA5A5, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 7'h04, 16'h0001, 2'b11, 16'h0001, 16'h0000, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 7'h04, 16'h00FF, 2'b11, 16'h00FF, 16'h0001, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 7'h04, 16'h0000, 2'b00, 16'h00FF, 16'h00FF, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 7'h05, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 7'h06, 16'hFFFF, 2'b11, 16'h0000, 16'h0000, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 7'h06, 16'hBEEF, 2'b10, 16'hBE00, 16'h0000, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 7'h06, 16'h0000, 2'b00, 16'hBE00, 16'hBE00, 1'b1};

    drive(1'b1, 1'b0, 7'h05, 16'h0000, 2'b00);
    c_req = 1'b0; c_wr = 1'b0; c_addr = '0; c_din = '0; c_wmask = '0;

    #12;
    chk("rst_ready", {ready_a, ready_b, c_ready}, 3'b000);
    chk("rst_busy", {busy_a, busy_b, c_busy}, 3'b110);
    chk("rst_dout", {dout_a, dout_b}, 32'h0);
    chk("rst_valid", {valid_a, valid_b, c_valid}, 3'b000);

    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("c_ready_first", c_ready, 1'b1);
    chk("a_ready_first", ready_a, 1'b0);
    count_sweep("sweep0", 1);

    tick();
    chk("first_read_valid", {valid_a, valid_b}, 2'b11);
    chk("first_read_dout", {dout_a, dout_b}, 32'h0);
    drive(1'b0, 1'b0, 7'h00, 16'h0000, 2'b00);
    tick();
    chk("valid_pulse", {valid_a, valid_b}, 2'b00);

    c_req = 1'b1; c_wr = 1'b1; c_addr = 4'h3; c_din = 32'h0; c_wmask = 4'b1111;
    tick();
    c_din = 32'hDEADBEEF; c_wmask = 4'b1010;
    tick();
    chk("c_wr_dout", c_dout, 32'hDE00BE00);
    chk("c_wr_valid", c_valid, 1'b0);
    c_wr = 1'b0; c_wmask = 4'b0000;
    tick();
    chk("c_rd_dout", c_dout, 32'hDE00BE00);
    chk("c_rd_valid", c_valid, 1'b1);
    c_req = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].wmask);
      tick();
      chk($sformatf("vec%0d_dout_a", i), dout_a, vecs[i].exp_a);
      chk($sformatf("vec%0d_dout_b", i), dout_b, vecs[i].exp_b);
      chk($sformatf("vec%0d_valid", i), {valid_a, valid_b}, {2{vecs[i].exp_v}});
    end

    drive(1'b1, 1'b0, 7'h01, 16'h0000, 2'b00);
    tick();
    chk("pre_rst_read", dout_a, 16'h0019);
    chk("pre_rst_valid", valid_a, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk("mid_acc_rst_ready", {ready_a, ready_b}, 2'b00);
    chk("mid_acc_rst_valid", {valid_a, valid_b}, 2'b00);
    chk("mid_acc_rst_dout", dout_a, 16'h0000);
    chk("mid_acc_rst_busy", busy_a, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 7'h07, 16'hFFFF, 2'b11);

    repeat (40) tick();
    chk("sweep40_busy", {busy_a, ready_a}, 2'b10);
    #3 reset = 1'b0;
    #1;
    chk("mid_sweep_rst", {busy_a, ready_a, valid_a}, 3'b100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    count_sweep("sweep_restart", 0);
    drive(1'b0, 1'b0, 7'h00, 16'h0000, 2'b00);

    drive(1'b1, 1'b0, 7'h07, 16'h0000, 2'b00);
    tick();
    chk("ignored_write_7", dout_a, 16'h0000);
    drive(1'b1, 1'b0, 7'h01, 16'h0000, 2'b00);
    tick();
    chk("cleared_1", {dout_a, dout_b}, 32'h0);
    chk("cleared_1_valid", {valid_a, valid_b}, 2'b11);
    drive(1'b0, 1'b0, 7'h00, 16'h0000, 2'b00);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
